// File: rtl/game_pkg.sv
// Shared game definitions: mode codes, song-level state encoding and default song limits.
// Also used by the scrolling display stage.
package game_pkg;

  localparam logic [2:0] MODE_LOAD = 3'd3;
  localparam logic [2:0] MODE_PLAY = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    WIN  = 2'd2,
    LOSE = 2'd3
  } state_t;

  localparam int SONG_STEPS_DEF  = 39;
  localparam int MISS_LIMIT_DEF  = 8;
  localparam int COMBO_BONUS_DEF = 8;
  localparam int SCORE_W_DEF     = 10;

  // Saturating add of a per-step miss count (0..2) onto the 4-bit miss counter.
  function automatic logic [3:0] sat_add_u4(input logic [3:0] a, input logic [1:0] b);
    logic [4:0] sum;
    sum = {1'b0, a} + {3'b000, b};
    if (sum[4]) begin
      sat_add_u4 = 4'd15;
    end else begin
      sat_add_u4 = sum[3:0];
    end
  endfunction

endpackage

// File: rtl/press_latch.sv
// Per-lane button edge detector with a sticky press latch that lives for one scroll step.
// pressed also reflects an edge in the current cycle so a press on the closing cycle still counts.
module press_latch (
  input  logic clk,
  input  logic n_rst,
  input  logic en,
  input  logic clr,
  input  logic pb,
  output logic pressed
);

  logic pb_prev_r;
  logic latch_r;
  logic edge_s;

  assign edge_s = pb & ~pb_prev_r;

  // Button history and sticky latch; clear wins so a same-cycle edge does not carry over.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      pb_prev_r <= 1'b0;
      latch_r   <= 1'b0;
    end else begin
      pb_prev_r <= pb;
      if (clr) begin
        latch_r <= 1'b0;
      end else if (en && edge_s) begin
        latch_r <= 1'b1;
      end else begin
        latch_r <= latch_r;
      end
    end
  end

  assign pressed = latch_r | (en & edge_s);

endmodule

// File: rtl/hit_judge.sv
// Judges each scroll step's hit-zone bits against latched presses, keeping score/combo/misses
// and the song-level IDLE/PLAY/WIN/LOSE state. All outputs are registered.
module hit_judge
  import game_pkg::*;
#(
  parameter int MISS_LIMIT  = MISS_LIMIT_DEF,
  parameter int SONG_STEPS  = SONG_STEPS_DEF,
  parameter int COMBO_BONUS = COMBO_BONUS_DEF,
  parameter int SCORE_W     = SCORE_W_DEF
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic [2:0]         mode,
  input  logic               scroll,
  input  logic               zone1,
  input  logic               zone2,
  input  logic               pb1,
  input  logic               pb2,
  output logic [SCORE_W-1:0] score,
  output logic [6:0]         combo,
  output logic [3:0]         misses,
  output logic [1:0]         hit_flash,
  output logic [1:0]         state
);

  localparam int                  STEP_W    = $clog2(SONG_STEPS + 1);
  localparam logic [3:0]          MISS_LIM  = 4'(MISS_LIMIT);
  localparam logic [STEP_W-1:0]   STEPS_END = STEP_W'(SONG_STEPS);
  localparam logic [6:0]          BONUS_MIN = 7'(COMBO_BONUS);
  localparam logic [SCORE_W-1:0]  SCORE_MAX = {SCORE_W{1'b1}};
  localparam logic [STEP_W-1:0]   STEP_ONE  = {{(STEP_W-1){1'b0}}, 1'b1};

  state_t               state_r, state_nxt_s;
  logic [SCORE_W-1:0]   score_r, score_nxt_s;
  logic [6:0]           combo_r, combo_nxt_s;
  logic [3:0]           misses_r, misses_nxt_s;
  logic [1:0]           flash_r, flash_nxt_s;
  logic [STEP_W-1:0]    step_r, step_nxt_s;

  logic                 load_s, en_s, judge_s, clr_s;
  logic                 p1_s, p2_s;
  logic [1:0]           hit_s, miss_s;
  logic [1:0]           h_s, m_s;
  logic [2:0]           gain_s;
  logic [SCORE_W:0]     score_sum_s;
  logic [SCORE_W-1:0]   score_upd_s;
  logic [7:0]           combo_sum_s;
  logic [6:0]           combo_upd_s;
  logic [3:0]           misses_upd_s;
  logic [STEP_W-1:0]    step_upd_s;

  // Presses are only collected while actively playing; pausing freezes them.
  assign load_s  = (mode == MODE_LOAD);
  assign en_s    = (state_r == PLAY) && (mode == MODE_PLAY);
  assign judge_s = en_s && scroll;
  assign clr_s   = load_s || judge_s;

  press_latch u_lane1 (
    .clk     (clk),
    .n_rst   (n_rst),
    .en      (en_s),
    .clr     (clr_s),
    .pb      (pb1),
    .pressed (p1_s)
  );

  press_latch u_lane2 (
    .clk     (clk),
    .n_rst   (n_rst),
    .en      (en_s),
    .clr     (clr_s),
    .pb      (pb2),
    .pressed (p2_s)
  );

  // A press with no note is a wrong press, so a lane misses whenever zone and press disagree.
  assign hit_s  = {zone1 & p1_s, zone2 & p2_s};
  assign miss_s = {zone1 ^ p1_s, zone2 ^ p2_s};
  assign h_s    = {1'b0, hit_s[1]} + {1'b0, hit_s[0]};
  assign m_s    = {1'b0, miss_s[1]} + {1'b0, miss_s[0]};

  assign gain_s      = (combo_r >= BONUS_MIN) ? {h_s, 1'b0} : {1'b0, h_s};
  assign score_sum_s = {1'b0, score_r} + {{(SCORE_W-2){1'b0}}, gain_s};
  assign score_upd_s = score_sum_s[SCORE_W] ? SCORE_MAX : score_sum_s[SCORE_W-1:0];

  assign combo_sum_s = {1'b0, combo_r} + {6'b000000, h_s};
  assign combo_upd_s = (m_s != 2'd0) ? 7'd0 :
                       (combo_sum_s[7] ? 7'd127 : combo_sum_s[6:0]);

  assign misses_upd_s = sat_add_u4(misses_r, m_s);
  assign step_upd_s   = step_r + STEP_ONE;

  // Next-state and next-counter logic; load mode overrides everything.
  always_comb begin
    state_nxt_s  = state_r;
    score_nxt_s  = score_r;
    combo_nxt_s  = combo_r;
    misses_nxt_s = misses_r;
    flash_nxt_s  = flash_r;
    step_nxt_s   = step_r;
    if (load_s) begin
      state_nxt_s  = IDLE;
      score_nxt_s  = {SCORE_W{1'b0}};
      combo_nxt_s  = 7'd0;
      misses_nxt_s = 4'd0;
      flash_nxt_s  = 2'b00;
      step_nxt_s   = {STEP_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (mode == MODE_PLAY) begin
            state_nxt_s = PLAY;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        PLAY: begin
          if (judge_s) begin
            score_nxt_s  = score_upd_s;
            combo_nxt_s  = combo_upd_s;
            misses_nxt_s = misses_upd_s;
            flash_nxt_s  = hit_s;
            step_nxt_s   = step_upd_s;
            // Losing takes precedence when the last step also brings the miss limit.
            if (misses_upd_s >= MISS_LIM) begin
              state_nxt_s = LOSE;
            end else if (step_upd_s == STEPS_END) begin
              state_nxt_s = WIN;
            end else begin
              state_nxt_s = PLAY;
            end
          end else begin
            state_nxt_s = PLAY;
          end
        end
        WIN, LOSE: begin
          state_nxt_s = state_r;
        end
        default: begin
          state_nxt_s = IDLE;
        end
      endcase
    end
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_r  <= IDLE;
      score_r  <= {SCORE_W{1'b0}};
      combo_r  <= 7'd0;
      misses_r <= 4'd0;
      flash_r  <= 2'b00;
      step_r   <= {STEP_W{1'b0}};
    end else begin
      state_r  <= state_nxt_s;
      score_r  <= score_nxt_s;
      combo_r  <= combo_nxt_s;
      misses_r <= misses_nxt_s;
      flash_r  <= flash_nxt_s;
      step_r   <= step_nxt_s;
    end
  end

  assign score     = score_r;
  assign combo     = combo_r;
  assign misses    = misses_r;
  assign hit_flash = flash_r;
  assign state     = state_r;

endmodule

// File: tb/tb_hit_judge.sv
// Bench for hit_judge: directed song scenarios with literal expectations, then random play,
// all compared every cycle against a step-level game model.
module tb_hit_judge;

  logic       clk = 1'b0;
  logic       n_rst;
  logic [2:0] mode;
  logic       scroll, zone1, zone2, pb1, pb2;
  logic [9:0] score;
  logic [6:0] combo;
  logic [3:0] misses;
  logic [1:0] hit_flash;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  // Game model: plain integers describing the player-visible rules.
  int m_state, m_score, m_combo, m_misses, m_flash, m_step;
  bit m_prev1, m_prev2, m_lat1, m_lat2;

  hit_judge dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .mode      (mode),
    .scroll    (scroll),
    .zone1     (zone1),
    .zone2     (zone2),
    .pb1       (pb1),
    .pb2       (pb2),
    .score     (score),
    .combo     (combo),
    .misses    (misses),
    .hit_flash (hit_flash),
    .state     (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the game model with the inputs seen at this clock edge.
  always @(posedge clk) begin : model
    bit e1, e2, q1, q2;
    int h, m;
    e1 = pb1 && !m_prev1;
    e2 = pb2 && !m_prev2;
    if (!n_rst) begin
      m_state = 0; m_score = 0; m_combo = 0; m_misses = 0; m_flash = 0; m_step = 0;
      m_prev1 = 0; m_prev2 = 0; m_lat1 = 0; m_lat2 = 0;
    end else begin
      m_prev1 = pb1;
      m_prev2 = pb2;
      if (mode == 3'd3) begin
        m_state = 0; m_score = 0; m_combo = 0; m_misses = 0; m_flash = 0; m_step = 0;
        m_lat1 = 0; m_lat2 = 0;
      end else if (m_state == 1 && mode == 3'd4) begin
        q1 = m_lat1 || e1;
        q2 = m_lat2 || e2;
        if (scroll) begin
          h = int'(zone1 && q1) + int'(zone2 && q2);
          m = int'(zone1 != q1) + int'(zone2 != q2);
          m_score = m_score + ((m_combo >= 8) ? 2 * h : h);
          if (m_score > 1023) m_score = 1023;
          if (m > 0) m_combo = 0;
          else m_combo = (m_combo + h > 127) ? 127 : m_combo + h;
          m_misses = (m_misses + m > 15) ? 15 : m_misses + m;
          m_flash = 2 * int'(zone1 && q1) + int'(zone2 && q2);
          m_step = m_step + 1;
          if (m_misses >= 8) m_state = 3;
          else if (m_step == 39) m_state = 2;
          m_lat1 = 0;
          m_lat2 = 0;
        end else begin
          m_lat1 = q1;
          m_lat2 = q2;
        end
      end else if (m_state == 0 && mode == 3'd4) begin
        m_state = 1;
      end
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      chk("score", int'(score), m_score);
      chk("combo", int'(combo), m_combo);
      chk("misses", int'(misses), m_misses);
      chk("hit_flash", int'(hit_flash), m_flash);
      chk("state", int'(state), m_state);
    end
  end

  task automatic cyc(input logic s, input logic z1, input logic z2, input logic b1, input logic b2);
    @(negedge clk);
    scroll = s; zone1 = z1; zone2 = z2; pb1 = b1; pb2 = b2;
  endtask

  // One scroll step: optional button rise, then the scroll cycle, then one settle cycle.
  task automatic step(input logic z1, input logic z2, input logic b1, input logic b2);
    cyc(1'b0, 1'b0, 1'b0, b1, b2);
    cyc(1'b1, z1, z2, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic go(input logic [2:0] m, input int n);
    mode = m;
    repeat (n) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic fresh();
    go(3'd3, 2);
    go(3'd4, 1);
  endtask

  initial begin
    n_rst = 1'b0; mode = 3'd3; scroll = 1'b0; zone1 = 1'b0; zone2 = 1'b0; pb1 = 1'b0; pb2 = 1'b0;
    repeat (2) @(negedge clk);
    started = 1'b1;
    chk("rst_state", int'(state), 0);
    chk("rst_score", int'(score), 0);
    n_rst = 1'b1;

    // Three lane-1 hits.
    fresh();
    chk("s1_play", int'(state), 1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b1, 1'b0);
      chk("s1_flash", int'(hit_flash), 2);
    end
    chk("s1_score", int'(score), 3);
    chk("s1_combo", int'(combo), 3);
    chk("s1_misses", int'(misses), 0);

    // Combo bonus, then a missed lane-2 note.
    fresh();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("s2_score8", int'(score), 8);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("s2_score9", int'(score), 10);
    chk("s2_combo9", int'(combo), 9);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("s2_combo0", int'(combo), 0);
    chk("s2_misses", int'(misses), 1);
    chk("s2_score", int'(score), 10);

    // Three wrong-press edges in one step count as one miss.
    fresh();
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("s3_misses", int'(misses), 1);
    // Edge coincident with scroll counts, and does not carry into the next step.
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("s3_same_cycle", int'(hit_flash), 2);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("s3_no_carry", int'(misses), 2);
    chk("s3_flash0", int'(hit_flash), 0);

    // Lose after four fully missed steps; further scrolls are inert.
    fresh();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("s4_misses", int'(misses), 8);
    chk("s4_lose", int'(state), 3);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("s4_hold", int'(misses), 8);
    go(3'd3, 1);
    chk("s4_idle", int'(state), 0);
    chk("s4_clear", int'(misses), 0);

    // Win after 39 empty steps.
    fresh();
    for (int i = 0; i < 39; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("s5_win", int'(state), 2);
    chk("s5_score", int'(score), 0);
    // Final step reaching both the song end and the miss limit loses.
    fresh();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 35; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("s5_still_play", int'(state), 1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("s5_lose", int'(state), 3);

    // Pause, resume and mid-song reset.
    fresh();
    step(1'b1, 1'b0, 1'b1, 1'b0);
    go(3'd2, 1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("s6_paused_score", int'(score), 1);
    chk("s6_paused_misses", int'(misses), 0);
    go(3'd4, 1);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("s6_resumed", int'(score), 2);
    n_rst = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_rst = 1'b1;
    chk("s6_rst_state", int'(state), 0);
    chk("s6_rst_score", int'(score), 0);
    chk("s6_rst_combo", int'(combo), 0);

    // Random play against the model.
    fresh();
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 39) == 0) begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3, 4, 5: mode = 3'd4;
          6, 7:             mode = 3'd3;
          8:                mode = 3'd2;
          default:          mode = 3'($urandom_range(0, 7));
        endcase
      end
      n_rst  = ($urandom_range(0, 999) != 0);
      scroll = ($urandom_range(0, 1) == 0);
      zone1  = ($urandom_range(0, 3) == 0);
      zone2  = ($urandom_range(0, 3) == 0);
      pb1    = ($urandom_range(0, 2) == 0);
      pb2    = ($urandom_range(0, 2) == 0);
    end
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
